// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

  localparam int unsigned XLEN_DEFAULT         = 32;
  localparam int unsigned DRAIN_CYCLES_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT        = 32;

  // Controller sequencing state: normal issue, draining for halt, halted.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  // Per-stage stall/flush/kill bundle so each stage takes a single port.
  typedef struct packed {
    logic if_stall;
    logic id_stall;
    logic ex_stall;
    logic mem_stall;
    logic if_flush;
    logic id_flush;
    logic wb_kill;
  } pipe_ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller for the 5-stage core: turns hazard
// sources into per-stage stall/flush controls, PC redirect, debug halt
// sequencing and saturating performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_load_use_i,
  input  logic             ex_redirect_i,
  input  logic [XLEN-1:0]  ex_target_i,
  input  logic             dmem_busy_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  output logic             if_stall_o,
  output logic             id_stall_o,
  output logic             ex_stall_o,
  output logic             mem_stall_o,
  output logic             if_flush_o,
  output logic             id_flush_o,
  output logic             wb_kill_o,
  output logic             pc_redirect_o,
  output logic [XLEN-1:0]  pc_target_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);

  ctrl_state_t     state_q;
  ctrl_state_t     state_d;
  logic [DCW-1:0]  drain_cnt_q;
  logic [DCW-1:0]  drain_cnt_d;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] target_d;
  pipe_ctrl_t      ctrl_s;
  logic            redirect_s;

  // Stall/flush/kill decode: reset, then dmem_busy, redirect, load-use;
  // fetch is additionally cut off whenever the core is draining or halted.
  always_comb begin
    ctrl_s     = '0;
    redirect_s = 1'b0;
    if (rst_i) begin
      ctrl_s.if_flush = 1'b1;
      ctrl_s.id_flush = 1'b1;
    end else if (dmem_busy_i) begin
      // Freeze everything; a pending redirect waits in the stalled EX stage.
      ctrl_s.if_stall  = 1'b1;
      ctrl_s.id_stall  = 1'b1;
      ctrl_s.ex_stall  = 1'b1;
      ctrl_s.mem_stall = 1'b1;
      ctrl_s.wb_kill   = 1'b1;
    end else begin
      if (ex_redirect_i) begin
        // Redirect squashes the dependent instruction, so load-use is moot.
        redirect_s      = 1'b1;
        ctrl_s.if_flush = 1'b1;
        ctrl_s.id_flush = 1'b1;
      end else if (id_load_use_i) begin
        ctrl_s.if_stall = 1'b1;
        ctrl_s.id_stall = 1'b1;
        ctrl_s.id_flush = 1'b1;
      end else begin
        redirect_s = 1'b0;
      end
      if (state_q != RUN) begin
        ctrl_s.if_stall = 1'b1;
        ctrl_s.if_flush = 1'b1;
      end else begin
        ctrl_s.wb_kill = 1'b0;
      end
    end
  end

  // Halt/drain sequencing and redirect-target hold.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    target_d    = redirect_s ? ex_target_i : target_q;
    case (state_q)
      RUN: begin
        if (halt_req_i && !dmem_busy_i && !ex_redirect_i) begin
          state_d     = DRAIN;
          drain_cnt_d = DCW'(DRAIN_CYCLES - 1);
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (dmem_busy_i) begin
          drain_cnt_d = drain_cnt_q;
        end else if (drain_cnt_q <= DCW'(1)) begin
          state_d     = HALTED;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q - DCW'(1);
        end
      end
      HALTED: begin
        if (resume_i) begin
          state_d = RUN;
        end else begin
          state_d = HALTED;
        end
      end
      default: begin
        state_d     = RUN;
        drain_cnt_d = '0;
      end
    endcase
  end

  // State, drain counter and held target registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      target_q    <= target_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (ctrl_s.id_stall),
    .cnt_o (stall_cycles_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (redirect_s),
    .cnt_o (flush_count_o)
  );

  assign if_stall_o    = ctrl_s.if_stall;
  assign id_stall_o    = ctrl_s.id_stall;
  assign ex_stall_o    = ctrl_s.ex_stall;
  assign mem_stall_o   = ctrl_s.mem_stall;
  assign if_flush_o    = ctrl_s.if_flush;
  assign id_flush_o    = ctrl_s.id_flush;
  assign wb_kill_o     = ctrl_s.wb_kill;
  assign pc_redirect_o = redirect_s;
  assign pc_target_o   = rst_i ? '0 : (redirect_s ? ex_target_i : target_q);
  assign halted_o      = (!rst_i) && (state_q == HALTED);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl (CNT_W=4 to exercise saturation).
module tb_pipeline_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_load_use_i;
  logic        ex_redirect_i;
  logic [31:0] ex_target_i;
  logic        dmem_busy_i;
  logic        halt_req_i;
  logic        resume_i;
  logic        if_stall_o, id_stall_o, ex_stall_o, mem_stall_o;
  logic        if_flush_o, id_flush_o, wb_kill_o, pc_redirect_o;
  logic [31:0] pc_target_o;
  logic        halted_o;
  logic [3:0]  stall_cycles_o;
  logic [3:0]  flush_count_o;

  int tests_run    = 0;
  int tests_failed = 0;

  pipeline_ctrl #(.XLEN(32), .DRAIN_CYCLES(4), .CNT_W(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_load_use_i  (id_load_use_i),
    .ex_redirect_i  (ex_redirect_i),
    .ex_target_i    (ex_target_i),
    .dmem_busy_i    (dmem_busy_i),
    .halt_req_i     (halt_req_i),
    .resume_i       (resume_i),
    .if_stall_o     (if_stall_o),
    .id_stall_o     (id_stall_o),
    .ex_stall_o     (ex_stall_o),
    .mem_stall_o    (mem_stall_o),
    .if_flush_o     (if_flush_o),
    .id_flush_o     (id_flush_o),
    .wb_kill_o      (wb_kill_o),
    .pc_redirect_o  (pc_redirect_o),
    .pc_target_o    (pc_target_o),
    .halted_o       (halted_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Control bits in order {if_stall,id_stall,ex_stall,mem_stall,if_flush,id_flush,wb_kill}.
  task automatic check_ctrl(input string tag, input logic [6:0] exp);
    check_eq(tag, 32'({if_stall_o, id_stall_o, ex_stall_o, mem_stall_o,
                       if_flush_o, id_flush_o, wb_kill_o}), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic lu, input logic red, input logic [31:0] tgt,
                       input logic busy, input logic halt, input logic res);
    id_load_use_i = lu;
    ex_redirect_i = red;
    ex_target_i   = tgt;
    dmem_busy_i   = busy;
    halt_req_i    = halt;
    resume_i      = res;
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check_ctrl("reset_ctrl", 7'b0000110);
    check_eq("reset_redir", 32'(pc_redirect_o), 32'd0);
    check_eq("reset_target", pc_target_o, 32'h0);
    check_eq("reset_halted", 32'(halted_o), 32'd0);
    step();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_ctrl("idle_ctrl", 7'b0000000);
    check_eq("idle_stallcnt", 32'(stall_cycles_o), 32'd0);
    check_eq("idle_flushcnt", 32'(flush_count_o), 32'd0);
    step();

    // Load-use bubble for one cycle
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_ctrl("lu_ctrl", 7'b1100010);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_ctrl("lu_after", 7'b0000000);
    check_eq("lu_stallcnt", 32'(stall_cycles_o), 32'd1);

    // Plain redirect
    drive(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    check_ctrl("red_ctrl", 7'b0000110);
    check_eq("red_pc", 32'(pc_redirect_o), 32'd1);
    check_eq("red_target", pc_target_o, 32'h100);
    step();
    drive(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check_eq("red_hold_target", pc_target_o, 32'h100);
    check_eq("red_after_pc", 32'(pc_redirect_o), 32'd0);
    check_eq("red_flushcnt", 32'(flush_count_o), 32'd1);

    // Busy holds a pending redirect for 3 cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
      check_ctrl("busy_ctrl", 7'b1111001);
      check_eq("busy_pc", 32'(pc_redirect_o), 32'd0);
      step();
    end
    drive(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
    check_eq("busy_rel_pc", 32'(pc_redirect_o), 32'd1);
    check_eq("busy_rel_target", pc_target_o, 32'h200);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("busy_flushcnt", 32'(flush_count_o), 32'd2);
    check_eq("busy_stallcnt", 32'(stall_cycles_o), 32'd4);

    // Redirect together with load-use: redirect only
    drive(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0);
    check_ctrl("rlu_ctrl", 7'b0000110);
    check_eq("rlu_pc", 32'(pc_redirect_o), 32'd1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("rlu_flushcnt", 32'(flush_count_o), 32'd3);
    check_eq("rlu_stallcnt", 32'(stall_cycles_o), 32'd4);

    // Halt without busy: halted four cycles after the request
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_ctrl("h_req_ctrl", 7'b0000000);
    step();
    check_ctrl("h_drain_ctrl", 7'b1000100);
    check_eq("h_d1_halted", 32'(halted_o), 32'd0);
    step();
    step();
    check_eq("h_d3_halted", 32'(halted_o), 32'd0);
    step();
    check_eq("h_halted", 32'(halted_o), 32'd1);
    check_ctrl("h_halted_ctrl", 7'b1000100);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check_eq("h_resume_same", 32'(halted_o), 32'd1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("h_resumed", 32'(halted_o), 32'd0);
    check_ctrl("h_resumed_ctrl", 7'b0000000);

    // Halt with a busy pulse in the second drain cycle: one extra cycle
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_ctrl("hb_busy_ctrl", 7'b1111001);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("hb_c4_halted", 32'(halted_o), 32'd0);
    step();
    check_eq("hb_c5_halted", 32'(halted_o), 32'd1);
    check_eq("hb_stallcnt", 32'(stall_cycles_o), 32'd5);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("hb_resumed", 32'(halted_o), 32'd0);

    // Reset mid-drain
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    step();
    check_ctrl("rd_drain_ctrl", 7'b1000100);
    rst_i = 1'b1;
    #1;
    check_ctrl("rd_rst_ctrl", 7'b0000110);
    check_eq("rd_rst_target", pc_target_o, 32'h0);
    check_eq("rd_rst_halted", 32'(halted_o), 32'd0);
    step();
    rst_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_ctrl("rd_run_ctrl", 7'b0000000);
    check_eq("rd_stallcnt", 32'(stall_cycles_o), 32'd0);
    check_eq("rd_flushcnt", 32'(flush_count_o), 32'd0);
    check_eq("rd_target", pc_target_o, 32'h0);

    // Saturation: 20 load-use cycles on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_stallcnt", 32'(stall_cycles_o), 32'd15);
    step();
    check_eq("sat_hold", 32'(stall_cycles_o), 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
